// File: rtl/rx_path.sv
// rx_path: UART serial receiver paired with the transmit path.
//
// Deserialises the Rx line into a WIDTH_SIZE-bit word (LSB first). It checks
// the stop bit and, when PF is latched high at the start bit, the even parity
// bit. The word and its error flags are held for the consumer behind a
// valid/ready register. A frame that completes while the previous word is
// still unaccepted is dropped, and overrun pulses for one cycle.
//
// Optional feature macro: RX_SYNC_EN
//   defined     - Rx passes through a two-flop synchroniser (reset to 1);
//                 all sample points move two cycles later.
//   not defined - Rx is used directly (same-clock loopback only).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   Rx          in   serial line, idles high
//   PF          in   parity enable, latched at start-bit detection
//   out_ready   in   consumer accepts the held word
//   data_out    out  received word
//   out_valid   out  data_out and the error flags are valid
//   parity_err  out  parity mismatch (qualified by out_valid)
//   frame_err   out  stop bit sampled low (qualified by out_valid)
//   overrun     out  one-cycle pulse when a completed frame is dropped
//   busy        out  a frame is in progress

module rx_path #(
    parameter int WIDTH_SIZE   = 32,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Rx,
    input  logic                  PF,
    input  logic                  out_ready,
    output logic [WIDTH_SIZE-1:0] data_out,
    output logic                  out_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(WIDTH_SIZE);

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH_SIZE - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    logic                  s;
    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [WIDTH_SIZE-1:0] shreg;
    logic                  pf_lat;
    logic                  par_bad;

`ifdef RX_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= Rx;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = Rx;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            pf_lat     <= 1'b0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // Consumer handshake; a completion later in this block takes
            // precedence and keeps out_valid high with the new word.
            if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!s) begin
                        state   <= ST_START;
                        cnt     <= '0;
                        pf_lat  <= PF;
                        par_bad <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt        <= '0;
                        shreg[idx] <= s;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= pf_lat ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PARITY: begin
                    if (cnt == BIT_M1) begin
                        cnt     <= '0;
                        par_bad <= (s != ^shreg);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt  <= '0;
                        busy <= 1'b0;
                        if (!out_valid || out_ready) begin
                            data_out   <= shreg;
                            parity_err <= par_bad;
                            frame_err  <= !s;
                            out_valid  <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        // A low stop bit must see the line return high before
                        // another start bit can be recognised.
                        state <= s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_path.sv
// tb_rx_path: self-checking bench for rx_path (WIDTH_SIZE=32, CLKS_PER_BIT=16).
// Frames are built bit by bit from the frame format and driven on Rx; the
// expected word, flags and completion cycle are derived from what was sent.

module tb_rx_path;

    localparam int W    = 32;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          Rx;
    logic          PF;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic          out_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int valid_rises = 0;
    int valid_rise_cyc = -1;
    int busy_rises = 0;
    int busy_fall_cyc = -1;
    int ov_pulses = 0;
    int ov_cyc = -1;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;

    rx_path #(
        .WIDTH_SIZE   (W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rx         (Rx),
        .PF         (PF),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event recorder, sampled away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
            valid_rises++;
            valid_rise_cyc = cyc;
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises++;
        if (busy !== 1'b1 && prev_busy === 1'b1) busy_fall_cyc = cyc;
        if (overrun === 1'b1) begin
            ov_pulses++;
            ov_cyc = cyc;
        end
        prev_valid = out_valid;
        prev_busy  = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1 phase; returns at posedge+1 phase with the stop bit
    // still on the line. pmode: 0 no parity, 1 correct parity, 2 wrong parity.
    task automatic send_frame(input logic [W-1:0] d, input int pmode,
                              input logic stop_bit, input logic flip_pf,
                              output int done_cyc);
        logic q[$];
        int   c0;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
        if (pmode != 0) q.push_back((^d) ^ (pmode == 2));
        q.push_back(stop_bit);
        PF = (pmode != 0);
        c0 = cyc;
        done_cyc = c0 + 1 + HALF + CPB * (q.size() - 1) + LAT;
        for (int b = 0; b < q.size(); b++) begin
            Rx = q[b];
            if (flip_pf && b == 3) PF = ~PF;
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ready;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Rx = 1'b1;
        PF = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity: got %b expected 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        int r0;
        r0 = valid_rises;
        PF = 1'b0;
        for (int b = 0; b < 6; b++) begin
            Rx = (b == 0) ? 1'b0 : b[0];
            repeat (CPB) @(posedge clk);
            #1;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        Rx = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after: got %b expected 0", busy); end
        repeat (40 * CPB) @(posedge clk);
        #1;
        n_checks++; if (valid_rises !== r0) begin n_fail++; $display("FAIL midreset_no_output: got %0d valid rises expected %0d", valid_rises, r0); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_clean;
        int done;
        out_ready = 1'b0;
        send_frame(32'h5555_5555, 0, 1'b1, 1'b0, done);
        n_checks++; if (data_out !== 32'h5555_5555) begin n_fail++; $display("FAIL clean_data: got %h expected 55555555", data_out); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b expected 1", out_valid); end
        n_checks++; if (valid_rise_cyc !== done) begin n_fail++; $display("FAIL clean_valid_time: got cycle %0d expected %0d", valid_rise_cyc, done); end
        n_checks++; if (busy_fall_cyc !== done) begin n_fail++; $display("FAIL clean_busy_fall: got cycle %0d expected %0d", busy_fall_cyc, done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL clean_parity: got %b expected 0", parity_err); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_frame: got %b expected 0", frame_err); end
        pulse_ready();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_parity;
        int done;
        send_frame(32'h5555_775D, 2, 1'b1, 1'b0, done);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b expected 1", parity_err); end
        n_checks++; if (data_out !== 32'h5555_775D) begin n_fail++; $display("FAIL parity_bad_data: got %h expected 5555775d", data_out); end
        n_checks++; if (valid_rise_cyc !== done) begin n_fail++; $display("FAIL parity_valid_time: got cycle %0d expected %0d", valid_rise_cyc, done); end
        pulse_ready();
        send_frame(32'h5555_775D, 1, 1'b1, 1'b0, done);
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good: got %b expected 0", parity_err); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL parity_good_valid: got %b expected 1", out_valid); end
        pulse_ready();
    endtask

    task automatic test_framing_break;
        int done;
        int r0;
        r0 = valid_rises;
        send_frame(32'h0000_00FF, 0, 1'b0, 1'b0, done);
        repeat (40 * CPB) @(posedge clk);
        #1;
        n_checks++; if (valid_rises !== r0 + 1) begin n_fail++; $display("FAIL break_once: got %0d frames expected %0d", valid_rises - r0, 1); end
        n_checks++; if (valid_rise_cyc !== done) begin n_fail++; $display("FAIL break_valid_time: got cycle %0d expected %0d", valid_rise_cyc, done); end
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_frame_err: got %b expected 1", frame_err); end
        n_checks++; if (data_out !== 32'h0000_00FF) begin n_fail++; $display("FAIL break_data: got %h expected 000000ff", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy: got %b expected 0", busy); end
        Rx = 1'b1;
        pulse_ready();
        repeat (CPB) @(posedge clk);
        #1;
        send_frame(32'h1234_5678, 0, 1'b1, 1'b0, done);
        n_checks++; if (data_out !== 32'h1234_5678) begin n_fail++; $display("FAIL recover_data: got %h expected 12345678", data_out); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL recover_frame: got %b expected 0", frame_err); end
        n_checks++; if (valid_rises !== r0 + 2) begin n_fail++; $display("FAIL recover_count: got %0d frames expected %0d", valid_rises - r0, 2); end
        pulse_ready();
    endtask

    task automatic test_glitch;
        int r0;
        int b0;
        r0 = valid_rises;
        b0 = busy_rises;
        Rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        Rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        n_checks++; if (busy_rises !== b0 + 1) begin n_fail++; $display("FAIL glitch_detect: got %0d busy rises expected %0d", busy_rises - b0, 1); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0 || valid_rises !== r0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back_overrun;
        int da, db, ov0, cb, exp_b, r0;
        out_ready = 1'b0;
        ov0 = ov_pulses;
        send_frame(32'hAAAA_AAAA, 0, 1'b1, 1'b0, da);
        send_frame(32'h0F0F_0F0F, 0, 1'b1, 1'b0, db);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (ov_pulses !== ov0 + 1) begin n_fail++; $display("FAIL overrun_count: got %0d pulses expected 1", ov_pulses - ov0); end
        n_checks++; if (ov_cyc !== db) begin n_fail++; $display("FAIL overrun_time: got cycle %0d expected %0d", ov_cyc, db); end
        n_checks++; if (data_out !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL overrun_data: got %h expected aaaaaaaa", data_out); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", out_valid); end
        pulse_ready();

        ov0 = ov_pulses;
        send_frame(32'hAAAA_AAAA, 0, 1'b1, 1'b0, da);
        r0 = valid_rises;
        cb = cyc;
        exp_b = cb + 1 + HALF + CPB * (W + 1) + LAT;
        fork
            send_frame(32'h0F0F_0F0F, 0, 1'b1, 1'b0, db);
            begin
                repeat (exp_b - 1 - cb) @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        n_checks++; if (db !== exp_b) begin n_fail++; $display("FAIL ready_time_model: got cycle %0d expected %0d", db, exp_b); end
        n_checks++; if (data_out !== 32'h0F0F_0F0F) begin n_fail++; $display("FAIL ready_data: got %h expected 0f0f0f0f", data_out); end
        n_checks++; if (out_valid !== 1'b1 || valid_rises !== r0) begin n_fail++; $display("FAIL ready_valid: got %b expected 1 held", out_valid); end
        n_checks++; if (ov_pulses !== ov0) begin n_fail++; $display("FAIL ready_no_overrun: got %0d pulses expected 0", ov_pulses - ov0); end
        pulse_ready();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ready_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_random;
        logic [W-1:0] d;
        int pmode, done;
        logic stop_bit, flip;
        for (int k = 0; k < 10; k++) begin
            d = $urandom;
            pmode = $urandom_range(0, 2);
            stop_bit = ($urandom_range(0, 3) != 0);
            flip = $urandom_range(0, 1);
            send_frame(d, pmode, stop_bit, flip, done);
            if (!stop_bit) begin
                Rx = 1'b1;
                repeat (CPB) @(posedge clk);
                #1;
            end
            n_checks++; if (data_out !== d) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", k, data_out, d); end
            n_checks++; if (parity_err !== (pmode == 2)) begin n_fail++; $display("FAIL rand_parity[%0d]: got %b expected %b", k, parity_err, pmode == 2); end
            n_checks++; if (frame_err !== !stop_bit) begin n_fail++; $display("FAIL rand_frame[%0d]: got %b expected %b", k, frame_err, !stop_bit); end
            n_checks++; if (valid_rise_cyc !== done) begin n_fail++; $display("FAIL rand_valid_time[%0d]: got cycle %0d expected %0d", k, valid_rise_cyc, done); end
            n_checks++; if (busy_fall_cyc !== done) begin n_fail++; $display("FAIL rand_busy_fall[%0d]: got cycle %0d expected %0d", k, busy_fall_cyc, done); end
            pulse_ready();
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_clean();
        test_parity();
        test_framing_break();
        test_glitch();
        test_back_to_back_overrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
